// File: rtl/fnn_pkg.sv
// Shared definitions for the fully-connected network datapath: feeder FSM
// states, the activation Q-format, and a helper for picking one neuron's
// value out of a concatenated output bus.
package fnn_pkg;

    // Activations and neuron outputs are signed Q(dataWidth-11).11.
    localparam int unsigned FRAC_BITS = 11;

    // Upper bounds for the generic slice helper below.
    localparam int unsigned MAX_DATA_W  = 32;
    localparam int unsigned MAX_NEURONS = 64;
    localparam int unsigned MAX_BUS_W   = MAX_DATA_W * MAX_NEURONS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DRAIN   = 2'd2,
        CAPTURE = 2'd3
    } feeder_state_t;

    // Extract neuron k (width bits wide) from a bus with neuron 0 in the LSBs.
    // Bits above width, or beyond the bus, read as zero.
    function automatic logic [MAX_DATA_W-1:0] neuron_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          width
    );
        logic [MAX_DATA_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < MAX_DATA_W; b++) begin
            if (b < width && (k * width + b) < MAX_BUS_W) begin
                r[b] = bus[k * width + b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_feeder.sv
// Input-side sequencer for one fully-connected layer. Streams numInputs
// activations from upstream onto the shared myinput bus, steers the neurons'
// freeze/pause controls so accumulation tracks the stream (including upstream
// stalls), waits for the last multiply-accumulate to settle, then latches all
// neuron outputs into the result bank with a one-cycle result_valid pulse.
module neuron_feeder
    import fnn_pkg::*;
#(
    parameter int unsigned numInputs   = 784,
    parameter int unsigned numNeurons  = 30,
    parameter int unsigned dataWidth   = 16,
    parameter int unsigned drainCycles = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [dataWidth-1:0]            in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [dataWidth-1:0]            myinput,
    output logic                            freeze,
    output logic                            pause,
    input  logic [numNeurons*dataWidth-1:0] neuron_out,
    output logic [numNeurons*dataWidth-1:0] result,
    output logic                            result_valid,
    output logic                            busy
);

    localparam int unsigned BusW   = numNeurons * dataWidth;
    localparam int unsigned IdxW   = $clog2(numInputs + 1);
    localparam int unsigned DrainW = (drainCycles > 1) ? $clog2(drainCycles) : 1;

    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(numInputs - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(drainCycles - 1);

    feeder_state_t         state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DrainW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [dataWidth-1:0]  myinput_q, myinput_d;
    logic                  freeze_q, freeze_d;
    logic                  pause_q, pause_d;
    logic [BusW-1:0]       result_q, result_d;
    logic                  result_valid_q, result_valid_d;

    logic                  xfer;
    logic                  first_sent;

    // Upstream handshake: only STREAM ever accepts data.
    assign in_ready   = (state_q == STREAM);
    assign xfer       = in_valid & in_ready;
    // idx counts forwarded values, so nonzero means the neurons are running.
    assign first_sent = (idx_q != '0);

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        drain_cnt_d    = drain_cnt_q;
        myinput_d      = myinput_q;
        freeze_d       = freeze_q;
        pause_d        = pause_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                freeze_d    = 1'b1;
                pause_d     = 1'b0;
                drain_cnt_d = '0;
                if (start) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end

            STREAM: begin
                if (xfer) begin
                    myinput_d = in_data;
                    freeze_d  = 1'b0;
                    pause_d   = 1'b0;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end else if (first_sent) begin
                    // Stall mid-stream: hold the neurons on the current value.
                    pause_d = 1'b1;
                end
                // Stall before the first value: freeze stays high, pause low.
            end

            DRAIN: begin
                // Neurons consume the final value in the first DRAIN cycle;
                // freeze rises behind it and the counter lets the MAC settle.
                freeze_d = 1'b1;
                pause_d  = 1'b0;
                if (drain_cnt_q == LastDrain) begin
                    state_d = CAPTURE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end

            CAPTURE: begin
                result_d       = neuron_out;
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any inference without publishing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            drain_cnt_q    <= '0;
            myinput_q      <= '0;
            freeze_q       <= 1'b1;
            pause_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            drain_cnt_q    <= drain_cnt_d;
            myinput_q      <= myinput_d;
            freeze_q       <= freeze_d;
            pause_q        <= pause_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign myinput      = myinput_q;
    assign freeze       = freeze_q;
    assign pause        = pause_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder (4 inputs, 2 neurons, 2 drain cycles).
// A per-cycle stimulus table is built first; a schedule-level model derives
// every expected output from it, then the run compares the DUT each cycle and
// finishes with hand-computed literal checks.
module tb_neuron_feeder;
    import fnn_pkg::*;

    localparam int unsigned NIN   = 4;
    localparam int unsigned NNEU  = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned DRAIN = 2;
    localparam int unsigned BW    = NNEU * DW;
    localparam int          NC    = 160;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, freeze, pause, result_valid, busy;
    logic [DW-1:0] in_data, myinput;
    logic [BW-1:0] neuron_out, result;

    neuron_feeder #(
        .numInputs  (NIN),
        .numNeurons (NNEU),
        .dataWidth  (DW),
        .drainCycles(DRAIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .myinput     (myinput),
        .freeze      (freeze),
        .pause       (pause),
        .neuron_out  (neuron_out),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stimulus table
    bit            st [NC];
    bit            vl [NC];
    bit            rs [NC];
    logic [DW-1:0] dt [NC];
    logic [BW-1:0] no [NC];
    int            n = 0;
    logic [BW-1:0] nout_cur = '0;

    // Expected outputs
    bit            e_ir [NC];
    bit            e_bs [NC];
    bit            e_fr [NC];
    bit            e_pa [NC];
    bit            e_rv [NC];
    logic [DW-1:0] e_my [NC];
    logic [BW-1:0] e_res[NC];

    // DUT log for the literal checks
    bit            l_fr [NC];
    bit            l_pa [NC];
    bit            l_rv [NC];
    bit            l_bs [NC];
    logic [DW-1:0] l_my [NC];
    logic [BW-1:0] l_res[NC];

    int n_cmp = 0;
    int n_bad = 0;
    int t1, t2, t3, t4, t5, t6;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit v, input logic [DW-1:0] d, input bit r);
        st[n] = s; vl[n] = v; dt[n] = d; rs[n] = r; no[n] = nout_cur;
        n++;
    endtask

    task automatic idle(input int k, input bit v);
        for (int i = 0; i < k; i++) cyc(1'b0, v, 16'h7777, 1'b0);
    endtask

    task automatic build_schedule();
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        idle(2, 0);
        // T1: plain inference; valid junk while not streaming must be ignored
        nout_cur = 32'h0042_1234;
        t1 = n; cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0800, 0);
        idle(6, 1);
        // T2: three-cycle stall after the second value
        nout_cur = 32'h1111_2222;
        t2 = n; cyc(1, 0, 0, 0);
        cyc(0, 1, 16'h0101, 0); cyc(0, 1, 16'h0202, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'hDEAD, 0);
        cyc(0, 1, 16'h0303, 0); cyc(0, 1, 16'h0404, 0);
        idle(6, 0);
        // T3: upstream silent for five cycles after start
        nout_cur = 32'h0AAA_0BBB;
        t3 = n; cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 16'hBEEF, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i * 16), 0);
        idle(6, 0);
        // T4: start pulses while streaming and draining
        nout_cur = 32'h0F0F_F0F0;
        t4 = n; cyc(1, 0, 0, 0);
        cyc(0, 1, 16'h0A01, 0); cyc(1, 1, 16'h0A02, 0);
        cyc(0, 1, 16'h0A03, 0); cyc(0, 1, 16'h0A04, 0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        idle(7, 0);
        // T5: reset in the first drain cycle, then a clean inference
        nout_cur = 32'h5555_6666;
        t5 = n; cyc(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'h0B00 + 16'(i), 0);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'h0C00 + 16'(i), 0);
        idle(6, 0);
        // T6: back-to-back inferences, second start in the result_valid cycle
        nout_cur = 32'h0123_0456;
        t6 = n; cyc(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i * 256), 0);
        idle(3, 0);
        nout_cur = 32'h789A_0BCD;
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i * 17), 0);
        idle(6, 0);
        idle(3, 0);
    endtask

    task automatic set_exp(input int c, input bit ir, input bit bs, input logic [DW-1:0] my,
                           input bit fr, input bit pa, input logic [BW-1:0] res, input bit rv);
        e_ir[c] = ir; e_bs[c] = bs; e_my[c] = my; e_fr[c] = fr;
        e_pa[c] = pa; e_res[c] = res; e_rv[c] = rv;
    endtask

    // Walk the schedule one inference at a time: find an accepted start, count
    // transfers until NIN are in, then the drain window and capture.
    task automatic build_model();
        int            c = 0;
        int            k;
        bit            prev_x, ab, rv_next = 0;
        logic [DW-1:0] cur_my = '0;
        logic [BW-1:0] cur_res = '0;
        while (c < n) begin
            if (rs[c]) begin
                set_exp(c, 0, 0, '0, 1, 0, '0, 0);
                cur_my = '0; cur_res = '0; rv_next = 0;
                c++;
                continue;
            end
            set_exp(c, 0, 0, cur_my, 1, 0, cur_res, rv_next);
            rv_next = 0;
            if (!st[c]) begin
                c++;
                continue;
            end
            c++; k = 0; ab = 0; prev_x = 0;
            while (k < NIN && c < n) begin
                if (rs[c]) begin ab = 1; break; end
                set_exp(c, 1, 1, cur_my, (k == 0), (k > 0 && !prev_x), cur_res, 0);
                prev_x = vl[c];
                if (vl[c]) begin cur_my = dt[c]; k++; end
                c++;
            end
            if (ab) continue;
            for (int d = 0; d <= DRAIN; d++) begin
                if (c >= n || rs[c]) break;
                set_exp(c, 0, 1, cur_my, (d > 0), 0, cur_res, 0);
                if (d == DRAIN) begin cur_res = no[c]; rv_next = 1; end
                c++;
            end
        end
    endtask

    function automatic int count_rv(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += int'(l_rv[i]);
        return s;
    endfunction

    function automatic int count_pa(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += int'(l_pa[i]);
        return s;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; neuron_out = '0;
        build_schedule();
        build_model();

        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            rst = rs[c]; start = st[c]; in_valid = vl[c]; in_data = dt[c]; neuron_out = no[c];
            @(negedge clk);
            l_fr[c] = freeze; l_pa[c] = pause; l_rv[c] = result_valid; l_bs[c] = busy;
            l_my[c] = myinput; l_res[c] = result;
            chk($sformatf("c%0d in_ready", c), 64'(in_ready), 64'(e_ir[c]));
            chk($sformatf("c%0d busy", c), 64'(busy), 64'(e_bs[c]));
            chk($sformatf("c%0d myinput", c), 64'(myinput), 64'(e_my[c]));
            chk($sformatf("c%0d freeze", c), 64'(freeze), 64'(e_fr[c]));
            chk($sformatf("c%0d pause", c), 64'(pause), 64'(e_pa[c]));
            chk($sformatf("c%0d result", c), 64'(result), 64'(e_res[c]));
            chk($sformatf("c%0d result_valid", c), 64'(result_valid), 64'(e_rv[c]));
        end

        // Reset state
        chk("rst freeze", 64'(l_fr[0]), 64'd1);
        chk("rst myinput", 64'(l_my[0]), 64'd0);
        chk("rst busy", 64'(l_bs[0]), 64'd0);
        // T1
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("t1 myinput+%0d", i), 64'(l_my[t1 + i]), 64'h0800);
            chk($sformatf("t1 freeze+%0d", i), 64'(l_fr[t1 + i]), 64'd0);
        end
        chk("t1 rv at +8", 64'(l_rv[t1 + 8]), 64'd1);
        chk("t1 rv count", 64'(count_rv(t1, t1 + 10)), 64'd1);
        chk("t1 result", 64'(l_res[t1 + 8]), 64'h0042_1234);
        chk("t1 neuron0", 64'(neuron_slice(MAX_BUS_W'(l_res[t1 + 8]), 0, DW)), 64'h1234);
        chk("t1 neuron1", 64'(neuron_slice(MAX_BUS_W'(l_res[t1 + 8]), 1, DW)), 64'h0042);
        chk("t1 myinput held", 64'(l_my[t1 + 10]), 64'h0800);
        // T2
        chk("t2 pause count", 64'(count_pa(t2, t2 + 13)), 64'd3);
        chk("t2 pause+4", 64'(l_pa[t2 + 4]), 64'd1);
        chk("t2 pause+6", 64'(l_pa[t2 + 6]), 64'd1);
        chk("t2 myinput hold", 64'(l_my[t2 + 6]), 64'h0202);
        chk("t2 rv at +11", 64'(l_rv[t2 + 11]), 64'd1);
        chk("t2 result", 64'(l_res[t2 + 11]), 64'h1111_2222);
        // T3
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("t3 freeze+%0d", i), 64'(l_fr[t3 + i]), 64'd1);
            chk($sformatf("t3 pause+%0d", i), 64'(l_pa[t3 + i]), 64'd0);
        end
        chk("t3 freeze drop", 64'(l_fr[t3 + 7]), 64'd0);
        chk("t3 first value", 64'(l_my[t3 + 7]), 64'h0010);
        chk("t3 rv at +13", 64'(l_rv[t3 + 13]), 64'd1);
        // T4
        chk("t4 rv count", 64'(count_rv(t4, t4 + 13)), 64'd1);
        chk("t4 rv at +8", 64'(l_rv[t4 + 8]), 64'd1);
        // T5
        chk("t5 reset freeze", 64'(l_fr[t5 + 5]), 64'd1);
        chk("t5 reset busy", 64'(l_bs[t5 + 5]), 64'd0);
        chk("t5 reset myinput", 64'(l_my[t5 + 5]), 64'd0);
        chk("t5 no partial result", 64'(l_res[t5 + 6]), 64'd0);
        chk("t5 rv none early", 64'(count_rv(t5, t5 + 14)), 64'd0);
        chk("t5 rv at +15", 64'(l_rv[t5 + 15]), 64'd1);
        chk("t5 result", 64'(l_res[t5 + 15]), 64'h5555_6666);
        // T6
        chk("t6 first result", 64'(l_res[t6 + 8]), 64'h0123_0456);
        for (int i = 6; i <= 9; i++) begin
            chk($sformatf("t6 freeze gap+%0d", i), 64'(l_fr[t6 + i]), 64'd1);
        end
        chk("t6 second rv", 64'(l_rv[t6 + 16]), 64'd1);
        chk("t6 second result", 64'(l_res[t6 + 16]), 64'h789A_0BCD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
